gate_pattern_gen: RTL and testbench

- Stimulus source that sits directly upstream of the combinational gate blocks (3-input NAND family).
- Walks the gate inputs through every input combination and holds each one for a programmable number of cycles.
- Replaces hand-written #delay stimulus with a synthesizable, start/done-handshaked sequencer usable on the board and in simulation.

---
 rtl/gate_pattern_gen_if.sv | 39 +++
 rtl/gate_pattern_gen.sv | 158 +++++++++++++++
 tb/tb_gate_pattern_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_pattern_gen_if.sv
// Handshake and pattern bus between gate_pattern_gen and whatever drives/consumes it.
// Optional checker signals appear only when GATE_PAT_CHECK_EN is defined.
interface gate_pattern_gen_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             mode;
  logic             pause;
  logic [WIDTH-1:0] pattern;
  logic             valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] step_idx;
`ifdef GATE_PAT_CHECK_EN
  logic             dut_y;
  logic [7:0]       err_cnt;
  logic             pass;

  modport master (
    output start, mode, pause, dut_y,
    input  pattern, valid, busy, done, step_idx, err_cnt, pass
  );

  modport slave (
    input  start, mode, pause, dut_y,
    output pattern, valid, busy, done, step_idx, err_cnt, pass
  );
`else
  modport master (
    output start, mode, pause,
    input  pattern, valid, busy, done, step_idx
  );

  modport slave (
    input  start, mode, pause,
    output pattern, valid, busy, done, step_idx
  );
`endif
endinterface

// File: rtl/gate_pattern_gen.sv
// Exhaustive input-pattern sequencer for the 3-input NAND gate blocks.
// Steps through all 2**WIDTH input combinations in binary or Gray order,
// holding each for HOLD_CYCLES clocks, with start/busy/done handshake.
// Optional macro GATE_PAT_CHECK_EN adds a NAND response checker
// (dut_y input, err_cnt and pass outputs).
module gate_pattern_gen #(
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst,
  gate_pattern_gen_if.slave bus
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0] STEP_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    hold_cnt, hold_next;
  logic [WIDTH-1:0] step_q, step_next;
  logic [WIDTH-1:0] pattern_q, pattern_next;
  logic             gray_q, gray_next;
  logic             valid_q, valid_next;
  logic             busy_q, busy_next;
  logic             done_q, done_next;
  logic             hold_end;

  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] idx,
                                              input logic gray);
    return gray ? (idx ^ (idx >> 1)) : idx;
  endfunction

  assign hold_end = (state == RUN) && !bus.pause && (hold_cnt == HOLD_LAST);

  // State register; reset aborts any sweep without producing done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: start only counts in IDLE, the last step's final hold ends the sweep.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (hold_end && (step_q == STEP_LAST)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the counters and registered outputs.
  always_comb begin
    hold_next    = hold_cnt;
    step_next    = step_q;
    pattern_next = pattern_q;
    gray_next    = gray_q;
    valid_next   = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        hold_next    = '0;
        step_next    = '0;
        pattern_next = '0;
        if (bus.start) begin
          gray_next  = bus.mode;
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end
      end
      RUN: begin
        valid_next = 1'b1;
        busy_next  = 1'b1;
        if (!bus.pause) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_next = '0;
            if (step_q != STEP_LAST) begin
              step_next    = step_q + 1'b1;
              pattern_next = encode(step_q + 1'b1, gray_q);
            end else begin
              step_next    = '0;
              pattern_next = '0;
              valid_next   = 1'b0;
              busy_next    = 1'b0;
              done_next    = 1'b1;
            end
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
      end
      default: begin
        hold_next    = '0;
        step_next    = '0;
        pattern_next = '0;
      end
    endcase
  end

  // Output and counter registers so every visible signal is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      step_q    <= '0;
      pattern_q <= '0;
      gray_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      hold_cnt  <= hold_next;
      step_q    <= step_next;
      pattern_q <= pattern_next;
      gray_q    <= gray_next;
      valid_q   <= valid_next;
      busy_q    <= busy_next;
      done_q    <= done_next;
    end
  end

  assign bus.pattern  = pattern_q;
  assign bus.step_idx = step_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef GATE_PAT_CHECK_EN
  logic [7:0] err_q;
  logic       pass_q;

  // Compare the gate output against NAND on each step's final hold cycle; pass latched in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.start)
        err_q <= '0;
      else if (hold_end && (bus.dut_y != ~&pattern_q) && (err_q != 8'hFF))
        err_q <= err_q + 8'd1;
      if (state == DONE)
        pass_q <= (err_q == 8'd0);
    end
  end

  assign bus.err_cnt = err_q;
  assign bus.pass    = pass_q;
`endif

endmodule

// File: tb/tb_gate_pattern_gen.sv
// Directed testbench for gate_pattern_gen (WIDTH=3, HOLD_CYCLES=10).
// Define GATE_PAT_CHECK_EN to also exercise the NAND checker.
module tb_gate_pattern_gen;

  localparam int W = 3;
  localparam int H = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  logic [2:0] gray_tbl [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  gate_pattern_gen_if #(.WIDTH(W)) bus ();

  gate_pattern_gen #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef GATE_PAT_CHECK_EN
  logic y_force = 1'b0;
  assign bus.dut_y = y_force | ~&bus.pattern;
`endif

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  logic [8:0] obs;
  assign obs = {bus.valid, bus.busy, bus.done, bus.step_idx, bus.pattern};

  task automatic start_sweep(input logic m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = ~m;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_cnt++;
    if (obs !== 9'd0) $display("[TB] FAIL reset_state got %h want %h", obs, 9'd0);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_binary_sweep;
    logic [8:0] exp;
    start_sweep(1'b0);
    for (int i = 0; i < 82; i++) begin
      if (i < 80)       exp = {3'b110, 3'(i / 10), 3'(i / 10)};
      else if (i == 80) exp = {3'b001, 6'd0};
      else              exp = 9'd0;
      check_cnt++;
      if (obs !== exp) $display("[TB] FAIL binary_sweep i=%0d got %h want %h", i, obs, exp);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_gray_sweep;
    logic [8:0] exp;
    logic [2:0] prev;
    prev = 3'd0;
    start_sweep(1'b1);
    for (int i = 0; i < 82; i++) begin
      if (i < 80)       exp = {3'b110, 3'(i / 10), gray_tbl[i / 10]};
      else if (i == 80) exp = {3'b001, 6'd0};
      else              exp = 9'd0;
      check_cnt++;
      if (obs !== exp) $display("[TB] FAIL gray_sweep i=%0d got %h want %h", i, obs, exp);
      else pass_cnt++;
      if ((i > 0) && (i < 80) && (i % 10 == 0)) begin
        check_cnt++;
        if ($countones(bus.pattern ^ prev) != 1)
          $display("[TB] FAIL gray_one_bit i=%0d got %b prev %b want 1 bit change", i, bus.pattern, prev);
        else pass_cnt++;
      end
      prev = bus.pattern;
      @(negedge clk);
    end
  endtask

  task automatic test_pause;
    logic [8:0] exp;
    int s;
    bus.pause = 1'b1;
    repeat (2) @(negedge clk);
    check_cnt++;
    if (obs !== 9'd0) $display("[TB] FAIL pause_idle got %h want %h", obs, 9'd0);
    else pass_cnt++;
    bus.pause = 1'b0;
    start_sweep(1'b0);
    for (int i = 0; i < 89; i++) begin
      if (i < 30)      s = i / 10;
      else if (i < 45) s = 3;
      else             s = (i - 5) / 10;
      if (s > 7) s = 7;
      if (i < 87)       exp = {3'b110, 3'(s), 3'(s)};
      else if (i == 87) exp = {3'b001, 6'd0};
      else              exp = 9'd0;
      check_cnt++;
      if (obs !== exp) $display("[TB] FAIL pause_sweep i=%0d got %h want %h", i, obs, exp);
      else pass_cnt++;
      bus.pause = ((i >= 32) && (i < 37)) || (i == 84) || (i == 85);
      @(negedge clk);
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp;
    start_sweep(1'b0);
    for (int i = 0; i < 82; i++) begin
      if (i < 80)       exp = {3'b110, 3'(i / 10), 3'(i / 10)};
      else if (i == 80) exp = {3'b001, 6'd0};
      else              exp = 9'd0;
      check_cnt++;
      if (obs !== exp) $display("[TB] FAIL restart_ignored i=%0d got %h want %h", i, obs, exp);
      else pass_cnt++;
      bus.start = (i == 40) || (i == 80);
      bus.mode  = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.mode  = 1'b0;
  endtask

  task automatic test_reset_mid_sweep;
    logic [8:0] exp;
    logic saw_done;
    start_sweep(1'b0);
    for (int i = 0; i <= 50; i++) begin
      exp = {3'b110, 3'(i / 10), 3'(i / 10)};
      check_cnt++;
      if (obs !== exp) $display("[TB] FAIL pre_reset i=%0d got %h want %h", i, obs, exp);
      else pass_cnt++;
      if (i < 50) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check_cnt++;
    if (obs !== 9'd0) $display("[TB] FAIL async_reset got %h want %h", obs, 9'd0);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check_cnt++;
    if (saw_done !== 1'b0) $display("[TB] FAIL no_done_after_reset got %b want 0", saw_done);
    else pass_cnt++;
    start_sweep(1'b0);
    check_cnt++;
    if (obs !== {3'b110, 6'd0}) $display("[TB] FAIL restart_step0 got %h want %h", obs, {3'b110, 6'd0});
    else pass_cnt++;
    repeat (10) @(negedge clk);
    check_cnt++;
    if (obs !== {3'b110, 3'd1, 3'd1}) $display("[TB] FAIL restart_step1 got %h want %h", obs, {3'b110, 3'd1, 3'd1});
    else pass_cnt++;
    repeat (75) @(negedge clk);
  endtask

`ifdef GATE_PAT_CHECK_EN
  task automatic test_checker;
    y_force = 1'b0;
    start_sweep(1'b0);
    repeat (81) @(negedge clk);
    check_cnt++;
    if ((bus.err_cnt !== 8'd0) || (bus.pass !== 1'b1))
      $display("[TB] FAIL checker_good err_cnt=%0d pass=%b want err_cnt=0 pass=1", bus.err_cnt, bus.pass);
    else pass_cnt++;
    y_force = 1'b1;
    start_sweep(1'b0);
    repeat (81) @(negedge clk);
    check_cnt++;
    if ((bus.err_cnt !== 8'd1) || (bus.pass !== 1'b0))
      $display("[TB] FAIL checker_stuck1 err_cnt=%0d pass=%b want err_cnt=1 pass=0", bus.err_cnt, bus.pass);
    else pass_cnt++;
    y_force = 1'b0;
    start_sweep(1'b0);
    check_cnt++;
    if (bus.err_cnt !== 8'd0)
      $display("[TB] FAIL checker_clear err_cnt=%0d want 0", bus.err_cnt);
    else pass_cnt++;
    repeat (82) @(negedge clk);
  endtask
`endif

  // Runs every scenario in order, then prints the summary.
  initial begin
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.pause = 1'b0;
    $display("[TB] gate_pattern_gen directed tests starting");
    test_reset();
    test_binary_sweep();
    test_gray_sweep();
    test_pause();
    test_back_to_back();
    test_reset_mid_sweep();
`ifdef GATE_PAT_CHECK_EN
    test_checker();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
